wb_stream_arbiter: RTL and testbench



---
 rtl/wb_stream_pkg.sv | 20 ++
 rtl/wb_rr_pick.sv | 35 +++
 rtl/wb_stream_arbiter.sv | 139 +++++++++++++
 tb/tb_wb_stream_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stream_pkg.sv
// Shared constants and arbiter state encoding for the stream DMA Wishbone fabric.
package wb_stream_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    GRANT     = 2'd1,
    WAIT_DROP = 2'd2
  } arb_state_t;

  // Index width for an n-entry requester vector; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: first requester after 'last', wrapping.
module wb_rr_pick
  import wb_stream_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  int best;
  int d;

  // Distance from last+1 (mod N) is the priority; the smallest distance wins.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    best = N;
    d    = 0;
    for (int j = 0; j < N; j++) begin
      d = j - int'(last) - 1;
      if (d < 0) d = d + N;
      if (req[j] && d < best) begin
        best   = d;
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/wb_stream_arbiter.sv
// N-to-1 Wishbone B4 master arbiter: round-robin per bus cycle, grant held for
// the whole cyc, stall watchdog errors out a master whose slave never answers.
module wb_stream_arbiter
  import wb_stream_pkg::*;
#(
  parameter int WB_AW       = 32,
  parameter int WB_DW       = 32,
  parameter int NUM_MASTERS = 2,
  parameter int TIMEOUT     = 1024
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_MASTERS*WB_AW-1:0]     wbm_adr_i,
  input  logic [NUM_MASTERS*WB_DW-1:0]     wbm_dat_i,
  input  logic [NUM_MASTERS*WB_DW/8-1:0]   wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]           wbm_we_i,
  input  logic [NUM_MASTERS-1:0]           wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]           wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]         wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]         wbm_bte_i,
  output logic [WB_DW-1:0]                 wbm_dat_o,
  output logic [NUM_MASTERS-1:0]           wbm_ack_o,
  output logic [NUM_MASTERS-1:0]           wbm_err_o,
  output logic [WB_AW-1:0]                 wbs_adr_o,
  output logic [WB_DW-1:0]                 wbs_dat_o,
  output logic [WB_DW/8-1:0]               wbs_sel_o,
  output logic                             wbs_we_o,
  output logic                             wbs_cyc_o,
  output logic                             wbs_stb_o,
  output logic [2:0]                       wbs_cti_o,
  output logic [1:0]                       wbs_bte_o,
  input  logic [WB_DW-1:0]                 wbs_dat_i,
  input  logic                             wbs_ack_i,
  input  logic                             wbs_err_i,
  output logic [NUM_MASTERS-1:0]           grant_o,
  output logic                             timeout_o
);

  localparam int N  = NUM_MASTERS;
  localparam int IW = idx_w(N);
  localparam int SW = WB_DW / 8;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  arb_state_t    state;
  logic [N-1:0]  grant;
  logic [IW-1:0] gidx;
  logic [IW-1:0] rr_last;
  logic [CW-1:0] stall_cnt;
  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;

  logic [N-1:0][WB_AW-1:0] adr_v;
  logic [N-1:0][WB_DW-1:0] dat_v;
  logic [N-1:0][SW-1:0]    sel_v;
  logic [N-1:0][2:0]       cti_v;
  logic [N-1:0][1:0]       bte_v;

  assign adr_v = wbm_adr_i;
  assign dat_v = wbm_dat_i;
  assign sel_v = wbm_sel_i;
  assign cti_v = wbm_cti_i;
  assign bte_v = wbm_bte_i;

  wb_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req  (wbm_cyc_i),
    .last (rr_last),
    .gnt  (pick_gnt),
    .idx  (pick_idx)
  );

  logic live, g_cyc, g_stb, stalled, fire;

  // Reset is gated in combinationally so nothing leaks to the masters while rst is held.
  assign live    = (state == GRANT) && !rst;
  assign g_cyc   = wbm_cyc_i[gidx];
  assign g_stb   = wbm_stb_i[gidx];
  assign stalled = g_cyc && g_stb && !wbs_ack_i && !wbs_err_i;
  assign fire    = (TIMEOUT > 0) && live && stalled && (stall_cnt == CW'(TIMEOUT - 1));

  assign wbs_cyc_o = live && g_cyc;
  assign wbs_stb_o = live && g_stb;
  assign wbs_we_o  = live && wbm_we_i[gidx];
  assign wbs_adr_o = live ? adr_v[gidx] : '0;
  assign wbs_dat_o = live ? dat_v[gidx] : '0;
  assign wbs_sel_o = live ? sel_v[gidx] : '0;
  assign wbs_cti_o = live ? cti_v[gidx] : '0;
  assign wbs_bte_o = live ? bte_v[gidx] : '0;
  assign wbm_dat_o = live ? wbs_dat_i : '0;
  assign grant_o   = grant;
  assign timeout_o = fire;

  for (genvar k = 0; k < N; k++) begin : g_resp
    assign wbm_ack_o[k] = live && grant[k] && wbs_ack_i;
    assign wbm_err_o[k] = live && grant[k] && (wbs_err_i || fire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      grant     <= '0;
      gidx      <= '0;
      rr_last   <= IW'(N - 1);
      stall_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|wbm_cyc_i) begin
            grant   <= pick_gnt;
            gidx    <= pick_idx;
            rr_last <= pick_idx;
            state   <= GRANT;
          end
        end
        GRANT: begin
          if (!g_cyc) begin
            grant <= '0;
            state <= IDLE;
          end else if (fire) begin
            state <= WAIT_DROP;
          end
        end
        WAIT_DROP: begin
          // Bus stays parked until the errored master acknowledges by dropping cyc.
          if (!g_cyc) begin
            grant <= '0;
            state <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          state <= IDLE;
        end
      endcase
      stall_cnt <= ((TIMEOUT > 0) && state == GRANT && stalled && !fire) ?
                   stall_cnt + 1'b1 : '0;
    end
  end

endmodule

// File: tb/tb_wb_stream_arbiter.sv
// Directed bench for wb_stream_arbiter with a cycle-level ownership model.
module tb_wb_stream_arbiter;
  import wb_stream_pkg::*;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  typedef logic [0:0] mid_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0][AW-1:0]   m_adr;
  logic [N-1:0][DW-1:0]   m_dat;
  logic [N-1:0][DW/8-1:0] m_sel;
  logic [N-1:0]           m_we, m_cyc, m_stb;
  logic [N-1:0][2:0]      m_cti;
  logic [N-1:0][1:0]      m_bte;

  logic [DW-1:0]   wbm_dat_o;
  logic [N-1:0]    wbm_ack_o, wbm_err_o, grant_o;
  logic [AW-1:0]   wbs_adr_o;
  logic [DW-1:0]   wbs_dat_o, wbs_dat_i;
  logic [DW/8-1:0] wbs_sel_o;
  logic            wbs_we_o, wbs_cyc_o, wbs_stb_o, wbs_ack_i, wbs_err_i, timeout_o;
  logic [2:0]      wbs_cti_o;
  logic [1:0]      wbs_bte_o;

  logic ack_en = 1'b1, ack_force = 1'b0, err_force = 1'b0;
  assign wbs_ack_i = (ack_en & wbs_cyc_o & wbs_stb_o) | ack_force;
  assign wbs_err_i = err_force;
  assign wbs_dat_i = ~wbs_adr_o;

  wb_stream_arbiter #(.WB_AW(AW), .WB_DW(DW), .NUM_MASTERS(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel), .wbm_we_i(m_we),
    .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb), .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(wbm_dat_o), .wbm_ack_o(wbm_ack_o), .wbm_err_o(wbm_err_o),
    .wbs_adr_o(wbs_adr_o), .wbs_dat_o(wbs_dat_o), .wbs_sel_o(wbs_sel_o), .wbs_we_o(wbs_we_o),
    .wbs_cyc_o(wbs_cyc_o), .wbs_stb_o(wbs_stb_o), .wbs_cti_o(wbs_cti_o), .wbs_bte_o(wbs_bte_o),
    .wbs_dat_i(wbs_dat_i), .wbs_ack_i(wbs_ack_i), .wbs_err_i(wbs_err_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: who owns the bus (-1 = nobody), whether it was errored out by the
  // watchdog, the last winner, and how long the current strobe has waited.
  int   own  = -1;
  bit   dead = 1'b0;
  int   rr   = N - 1;
  int   wt   = 0;

  always @(negedge clk) begin : cmp
    bit   live, fire;
    mid_t oi;
    int   c;
    oi   = (own < 0) ? mid_t'(0) : mid_t'(own);
    live = !rst && own >= 0 && !dead;
    fire = live && m_cyc[oi] && m_stb[oi] && !wbs_ack_i && !wbs_err_i && wt == TO - 1;
    if (chk_en) begin
      chk("cmp_grant",   grant_o,   (own >= 0) ? (64'd1 << own) : 64'd0);
      chk("cmp_cyc",     wbs_cyc_o, live && m_cyc[oi]);
      chk("cmp_stb",     wbs_stb_o, live && m_stb[oi]);
      chk("cmp_we",      wbs_we_o,  live && m_we[oi]);
      chk("cmp_adr",     wbs_adr_o, live ? m_adr[oi] : '0);
      chk("cmp_wdat",    wbs_dat_o, live ? m_dat[oi] : '0);
      chk("cmp_sel",     wbs_sel_o, live ? m_sel[oi] : '0);
      chk("cmp_cti",     wbs_cti_o, live ? m_cti[oi] : '0);
      chk("cmp_bte",     wbs_bte_o, live ? m_bte[oi] : '0);
      chk("cmp_rdat",    wbm_dat_o, live ? wbs_dat_i : '0);
      chk("cmp_ack",     wbm_ack_o, (live && wbs_ack_i) ? (64'd1 << own) : 64'd0);
      chk("cmp_err",     wbm_err_o, (live && (wbs_err_i || fire)) ? (64'd1 << own) : 64'd0);
      chk("cmp_timeout", timeout_o, fire);
    end
    // advance the model across the coming rising edge
    if (rst) begin
      own = -1; dead = 1'b0; rr = N - 1; wt = 0;
    end else if (own < 0) begin
      for (int s = 1; s <= N; s++) begin
        c = (rr + s) % N;
        if (own < 0 && m_cyc[c]) own = c;
      end
      if (own >= 0) begin rr = own; wt = 0; end
    end else if (!m_cyc[oi]) begin
      own = -1; dead = 1'b0; wt = 0;
    end else if (fire) begin
      dead = 1'b1; wt = 0;
    end else if (!dead && m_stb[oi] && !wbs_ack_i && !wbs_err_i) begin
      wt++;
    end else begin
      wt = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Master-side burst: raises cyc/stb, advances on each ack, drops cyc after the
  // last one. lat counts cycles spent waiting for the grant.
  task automatic run_burst(input mid_t m, input logic [31:0] adr, input int beats,
                           output int acks, output int lat);
    int guard;
    bit got, acked;
    acks = 0; lat = 0; guard = 0; got = 1'b0;
    m_adr[m] = adr; m_dat[m] = ~adr ^ 32'h5A5A_0000; m_we[m] = adr[8];
    m_sel[m] = adr[7:4] | 4'h1; m_bte[m] = BTE_LINEAR;
    m_cti[m] = (beats > 1) ? CTI_INCR : CTI_CLASSIC;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
    while (acks < beats && guard < 300) begin
      @(negedge clk);
      if (!got && grant_o[m]) got = 1'b1;
      if (!got) lat++;
      acked = wbm_ack_o[m];
      if (acked) acks++;
      tick();
      guard++;
      if (acked) m_adr[m] = m_adr[m] + 32'd4;
      if (beats > 1 && acks == beats - 1) m_cti[m] = CTI_EOB;
    end
    if (guard >= 300) chk("burst_bound", 64'(acks), 64'(beats));
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_cti[m] = CTI_CLASSIC;
  endtask

  initial begin
    #100000;
    $display("FAIL global_time_limit: got running, expected finished");
    $fatal(1, "time limit");
  end

  initial begin
    int a0, a1, l0, l1, cnt;
    bit got_err;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0;
    tick();
    chk_en = 1'b1;
    tick();
    @(negedge clk);
    chk("rst_grant", grant_o, 0);
    chk("rst_cyc", wbs_cyc_o, 0);
    chk("rst_resp", {wbm_ack_o, wbm_err_o, timeout_o}, 0);
    tick();
    rst = 1'b0;
    tick();

    // single master, 4-beat INCR
    run_burst(1'b0, 32'h100, 4, a0, l0);
    chk("t1_lat", l0, 1);
    chk("t1_acks", a0, 4);
    tick();
    @(negedge clk);
    chk("t1_idle_grant", grant_o, 0);
    tick();

    // simultaneous request after m0 last won: m1 first, m0 after one idle gap
    fork
      run_burst(1'b0, 32'h200, 4, a0, l0);
      run_burst(1'b1, 32'h300, 4, a1, l1);
    join
    chk("t2a_m1_lat", l1, 1);
    chk("t2a_m0_lat", l0, 7);
    chk("t2a_acks", {a0[7:0], a1[7:0]}, 16'h0404);

    // from reset: m0 first
    tick(); rst = 1'b1; tick(); tick(); rst = 1'b0; tick();
    fork
      run_burst(1'b0, 32'h400, 2, a0, l0);
      run_burst(1'b1, 32'h500, 2, a1, l1);
    join
    chk("t2b_m0_lat", l0, 1);
    chk("t2b_m1_lat", l1, 5);
    tick(); tick();

    // m1 arrives during m0's 8-beat burst
    fork
      run_burst(1'b0, 32'h600, 8, a0, l0);
      begin
        repeat (3) tick();
        run_burst(1'b1, 32'h700, 2, a1, l1);
      end
    join
    chk("t3_m0_acks", a0, 8);
    chk("t3_m0_lat", l0, 1);
    chk("t3_m1_lat", l1, 8);
    chk("t3_m1_acks", a1, 2);
    tick(); tick();

    // watchdog: silent slave for m0, m1 waiting
    ack_en = 1'b0;
    m_adr[0] = 32'h800; m_cti[0] = CTI_CLASSIC; m_adr[1] = 32'h900;
    m_cyc = 2'b11; m_stb = 2'b11;
    cnt = 0; got_err = 1'b0;
    for (int i = 0; i < 40 && !got_err; i++) begin
      @(negedge clk);
      if (grant_o[0]) cnt++;
      if (wbm_err_o[0]) begin
        got_err = 1'b1;
        chk("t4_timeout_pulse", timeout_o, 1);
      end
      tick();
    end
    chk("t4_err_seen", got_err, 1);
    chk("t4_err_cycle", cnt, 16);
    ack_en = 1'b1;
    @(negedge clk);
    chk("t4_wait_cyc", wbs_cyc_o, 0);
    chk("t4_timeout_once", timeout_o, 0);
    chk("t4_hold_grant", grant_o, 2'b01);
    tick();
    @(negedge clk);
    chk("t4_wait_cyc2", wbs_cyc_o, 0);
    tick();
    m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    run_burst(1'b1, 32'h900, 1, a1, l1);
    chk("t4_m1_lat", l1, 2);
    chk("t4_m1_acks", a1, 1);
    tick(); tick();

    // slave err passes through, grant held while cyc stays up
    ack_en = 1'b0;
    m_adr[1] = 32'hB00; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick();
    err_force = 1'b1;
    @(negedge clk);
    chk("t7_err", wbm_err_o, 2'b10);
    chk("t7_no_ack", wbm_ack_o, 0);
    tick();
    err_force = 1'b0;
    @(negedge clk);
    chk("t7_hold_grant", grant_o, 2'b10);
    chk("t7_hold_cyc", wbs_cyc_o, 1);
    tick();
    m_cyc[1] = 1'b0; m_stb[1] = 1'b0;
    tick(); tick();

    // ack lands on the 16th stalled cycle: ack wins, no timeout
    m_adr[0] = 32'hA00; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    repeat (16) tick();
    ack_force = 1'b1;
    @(negedge clk);
    chk("t5_ack", wbm_ack_o, 2'b01);
    chk("t5_no_err", wbm_err_o, 0);
    chk("t5_no_timeout", timeout_o, 0);
    tick();
    ack_force = 1'b0; m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
    ack_en = 1'b1;
    tick(); tick();

    // reset in beat 3 of an 8-beat burst; m1 pending with m0 as last winner
    m_adr[0] = 32'hC00; m_cti[0] = CTI_INCR; m_cyc[0] = 1'b1; m_stb[0] = 1'b1;
    tick();
    m_adr[1] = 32'hD00; m_cyc[1] = 1'b1; m_stb[1] = 1'b1;
    tick(); tick();
    rst = 1'b1;
    @(negedge clk);
    chk("t6_no_ack_in_rst", wbm_ack_o, 0);
    tick();
    @(negedge clk);
    chk("t6_rst_cyc", wbs_cyc_o, 0);
    chk("t6_rst_grant", grant_o, 0);
    tick();
    rst = 1'b0;
    tick();
    @(negedge clk);
    chk("t6_m0_priority", grant_o, 2'b01);
    tick();
    m_cyc = '0; m_stb = '0;
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
